// File: rtl/psr_exception_unit.sv
// CPSR and banked SPSR owner with prioritised FIQ/IRQ/UND/SWI entry and ERET return.
// Entry runs SAVE -> LINK -> VECTOR and drives the banked rf and PC write ports.
module psr_exception_unit #(
  parameter int unsigned NUM_IRQ  = 8,
  parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               fiq_req,
  input  logic               und_req,
  input  logic               swi_req,
  input  logic               eret_req,
  input  logic [31:0]        eret_pc,
  input  logic               instr_boundary,
  input  logic [31:0]        pc_cur,
  input  logic               cpsr_wr_en,
  input  logic [31:0]        cpsr_wr_data,
  input  logic [3:0]         cpsr_wr_mask,
  input  logic               nzcv_wr_en,
  input  logic [3:0]         nzcv,
  output logic [31:0]        cpsr,
  output logic [31:0]        spsr_cur,
  output logic               rf_we,
  output logic [3:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic [4:0]         rf_mode,
  output logic               pc_we,
  output logic [31:0]        pc_new,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               busy
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [4:0] M_USR = 5'b10000;
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_UND = 5'b11011;
  localparam logic [4:0] M_SYS = 5'b11111;

  typedef enum logic [2:0] {S_IDLE, S_SAVE, S_LINK, S_VECTOR, S_RET} state_e;
  typedef enum logic [1:0] {EX_FIQ, EX_IRQ, EX_UND, EX_SWI} exc_e;

  state_e           state_q, state_d;
  exc_e             kind_q, kind_d;
  logic [31:0]      cpsr_q, cpsr_d;
  logic [31:0]      spsr_fiq_q, spsr_fiq_d, spsr_irq_q, spsr_irq_d;
  logic [31:0]      spsr_svc_q, spsr_svc_d, spsr_und_q, spsr_und_d;
  logic [31:0]      lr_q, lr_d, eret_pc_q, eret_pc_d;
  logic [IDX_W-1:0] idx_q, idx_d, irq_win;
  logic [4:0]       tgt_mode;
  logic [31:0]      vec_addr;
  logic [3:0]       mask_eff;
  logic             fiq_take, irq_take;

  function automatic logic mode_ok(input logic [4:0] m);
    case (m)
      M_USR, M_FIQ, M_IRQ, M_SVC, M_UND, M_SYS: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // Scan downward so the lowest set index is the last assignment and wins.
  always_comb begin
    irq_win = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (irq_req[i-1]) irq_win = IDX_W'(i - 1);
    end
  end

  always_comb begin
    case (kind_q)
      EX_FIQ:  begin tgt_mode = M_FIQ; vec_addr = VEC_BASE + 32'h1C; end
      EX_IRQ:  begin tgt_mode = M_IRQ; vec_addr = VEC_BASE + 32'h18; end
      EX_UND:  begin tgt_mode = M_UND; vec_addr = VEC_BASE + 32'h04; end
      default: begin tgt_mode = M_SVC; vec_addr = VEC_BASE + 32'h08; end
    endcase
  end

  always_comb begin
    case (cpsr_q[4:0])
      M_FIQ:   spsr_cur = spsr_fiq_q;
      M_IRQ:   spsr_cur = spsr_irq_q;
      M_SVC:   spsr_cur = spsr_svc_q;
      M_UND:   spsr_cur = spsr_und_q;
      default: spsr_cur = '0;
    endcase
  end

  assign fiq_take = fiq_req & ~cpsr_q[6];
  assign irq_take = (|irq_req) & ~cpsr_q[7];
  assign mask_eff = (cpsr_q[4:0] == M_USR) ? {cpsr_wr_mask[3], 3'b000} : cpsr_wr_mask;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    cpsr_d     = cpsr_q;
    spsr_fiq_d = spsr_fiq_q;
    spsr_irq_d = spsr_irq_q;
    spsr_svc_d = spsr_svc_q;
    spsr_und_d = spsr_und_q;
    lr_d       = lr_q;
    eret_pc_d  = eret_pc_q;
    idx_d      = idx_q;
    case (state_q)
      S_IDLE: begin
        if (instr_boundary && (fiq_take || irq_take || und_req || swi_req || eret_req)) begin
          state_d = S_SAVE;
          if (fiq_take) begin
            kind_d = EX_FIQ;
            lr_d   = pc_cur + 32'd4;
          end else if (irq_take) begin
            kind_d = EX_IRQ;
            lr_d   = pc_cur + 32'd4;
            idx_d  = irq_win;
          end else if (und_req) begin
            kind_d = EX_UND;
            lr_d   = pc_cur;
          end else if (swi_req) begin
            kind_d = EX_SWI;
            lr_d   = pc_cur;
          end else begin
            state_d   = S_RET;
            eret_pc_d = eret_pc;
          end
        end else begin
          // Flags first so a same-cycle MSR to byte 3 overrides them.
          if (nzcv_wr_en && !(cpsr_wr_en && cpsr_wr_mask[3])) cpsr_d[31:28] = nzcv;
          if (cpsr_wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
              if (mask_eff[b]) cpsr_d[8*b +: 8] = cpsr_wr_data[8*b +: 8];
            end
            if (mask_eff[0] && !mode_ok(cpsr_wr_data[4:0])) cpsr_d[4:0] = cpsr_q[4:0];
          end
        end
      end
      S_SAVE: begin
        case (kind_q)
          EX_FIQ:  spsr_fiq_d = cpsr_q;
          EX_IRQ:  spsr_irq_d = cpsr_q;
          EX_UND:  spsr_und_d = cpsr_q;
          default: spsr_svc_d = cpsr_q;
        endcase
        cpsr_d[4:0] = tgt_mode;
        cpsr_d[5]   = 1'b0;
        cpsr_d[7]   = 1'b1;
        if (kind_q == EX_FIQ) cpsr_d[6] = 1'b1;
        state_d = S_LINK;
      end
      S_LINK:   state_d = S_VECTOR;
      S_VECTOR: state_d = S_IDLE;
      S_RET: begin
        case (cpsr_q[4:0])
          M_FIQ, M_IRQ, M_SVC, M_UND: cpsr_d = spsr_cur;
          default:                    cpsr_d = cpsr_q;
        endcase
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      kind_q     <= EX_FIQ;
      cpsr_q     <= 32'h0000_00D3;
      spsr_fiq_q <= '0;
      spsr_irq_q <= '0;
      spsr_svc_q <= '0;
      spsr_und_q <= '0;
      lr_q       <= '0;
      eret_pc_q  <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cpsr_q     <= cpsr_d;
      spsr_fiq_q <= spsr_fiq_d;
      spsr_irq_q <= spsr_irq_d;
      spsr_svc_q <= spsr_svc_d;
      spsr_und_q <= spsr_und_d;
      lr_q       <= lr_d;
      eret_pc_q  <= eret_pc_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_mode  = '0;
    pc_we    = 1'b0;
    pc_new   = '0;
    irq_ack  = '0;
    case (state_q)
      S_LINK: begin
        rf_we    = 1'b1;
        rf_waddr = 4'd14;
        rf_wdata = lr_q;
        rf_mode  = tgt_mode;
      end
      S_VECTOR: begin
        pc_we  = 1'b1;
        pc_new = vec_addr;
        if (kind_q == EX_IRQ) irq_ack = NUM_IRQ'(1) << idx_q;
      end
      S_RET: begin
        pc_we  = 1'b1;
        pc_new = eret_pc_q;
      end
      default: ;
    endcase
  end

  assign cpsr = cpsr_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_psr_exception_unit.sv
// Directed bench for psr_exception_unit: entry, priority, masking, MSR, ERET and reset abort.
module tb_psr_exception_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_req;
  logic        fiq_req, und_req, swi_req, eret_req;
  logic [31:0] eret_pc, pc_cur, cpsr_wr_data;
  logic        instr_boundary, cpsr_wr_en, nzcv_wr_en;
  logic [3:0]  cpsr_wr_mask, nzcv;
  logic [31:0] cpsr, spsr_cur, rf_wdata, pc_new;
  logic        rf_we, pc_we, busy;
  logic [3:0]  rf_waddr;
  logic [4:0]  rf_mode;
  logic [7:0]  irq_ack;

  int errors = 0;
  int checks = 0;

  psr_exception_unit #(.NUM_IRQ(8), .VEC_BASE(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .irq_req(irq_req), .fiq_req(fiq_req), .und_req(und_req),
    .swi_req(swi_req), .eret_req(eret_req), .eret_pc(eret_pc),
    .instr_boundary(instr_boundary), .pc_cur(pc_cur), .cpsr_wr_en(cpsr_wr_en),
    .cpsr_wr_data(cpsr_wr_data), .cpsr_wr_mask(cpsr_wr_mask), .nzcv_wr_en(nzcv_wr_en),
    .nzcv(nzcv), .cpsr(cpsr), .spsr_cur(spsr_cur), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_mode(rf_mode), .pc_we(pc_we), .pc_new(pc_new),
    .irq_ack(irq_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_reqs();
    irq_req = '0; fiq_req = 0; und_req = 0; swi_req = 0; eret_req = 0;
    instr_boundary = 0; cpsr_wr_en = 0; nzcv_wr_en = 0;
  endtask

  task automatic msr(input logic [31:0] data, input logic [3:0] mask);
    cpsr_wr_en = 1; cpsr_wr_data = data; cpsr_wr_mask = mask;
    @(negedge clk);
    cpsr_wr_en = 0;
  endtask

  // Caller has set up an accepted request; this walks SAVE, LINK, VECTOR and back to IDLE.
  task automatic expect_entry(input string tag, input logic [31:0] e_cpsr, input logic [31:0] e_spsr,
                              input logic [31:0] e_lr, input logic [4:0] e_mode,
                              input logic [31:0] e_vec, input logic [7:0] e_ack);
    @(negedge clk);
    clear_reqs();
    check_eq({tag, ".save_busy"}, 32'(busy), 32'd1);
    check_eq({tag, ".save_rfwe"}, 32'(rf_we), 32'd0);
    @(negedge clk);
    check_eq({tag, ".cpsr"}, cpsr, e_cpsr);
    check_eq({tag, ".spsr"}, spsr_cur, e_spsr);
    check_eq({tag, ".rf_we"}, 32'(rf_we), 32'd1);
    check_eq({tag, ".rf_waddr"}, 32'(rf_waddr), 32'd14);
    check_eq({tag, ".lr"}, rf_wdata, e_lr);
    check_eq({tag, ".rf_mode"}, 32'(rf_mode), 32'(e_mode));
    check_eq({tag, ".link_pcwe"}, 32'(pc_we), 32'd0);
    @(negedge clk);
    check_eq({tag, ".pc_we"}, 32'(pc_we), 32'd1);
    check_eq({tag, ".vector"}, pc_new, e_vec);
    check_eq({tag, ".irq_ack"}, 32'(irq_ack), 32'(e_ack));
    check_eq({tag, ".vec_rfwe"}, 32'(rf_we), 32'd0);
    @(negedge clk);
    check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".idle_pcwe"}, 32'(pc_we), 32'd0);
    check_eq({tag, ".idle_ack"}, 32'(irq_ack), 32'd0);
  endtask

  initial begin
    rst = 1;
    clear_reqs();
    eret_pc = '0; pc_cur = '0; cpsr_wr_data = '0; cpsr_wr_mask = '0; nzcv = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.cpsr", cpsr, 32'h0000_00D3);
    check_eq("rst.spsr", spsr_cur, 32'h0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.strobes", {29'd0, rf_we, pc_we, |irq_ack}, 32'd0);
    check_eq("rst.pc_new", pc_new, 32'h0);
    check_eq("rst.rf_bus", {23'd0, rf_mode, rf_waddr}, 32'd0);
    rst = 0;
    @(negedge clk);

    msr(32'h0000_001A, 4'b0001);
    check_eq("msr.badmode", cpsr, 32'h0000_0013);
    msr(32'h0000_0010, 4'b0001);
    check_eq("msr.to_usr", cpsr, 32'h0000_0010);
    check_eq("usr.spsr", spsr_cur, 32'h0);

    irq_req = 8'b0010_0100; pc_cur = 32'h100; instr_boundary = 1;
    expect_entry("irq", 32'h92, 32'h10, 32'h104, 5'b10010, 32'h18, 8'b0000_0100);

    msr(32'h0000_0013, 4'b0001);
    fiq_req = 1; irq_req = 8'hFF; pc_cur = 32'h120; instr_boundary = 1;
    expect_entry("fiq_prio", 32'hD1, 32'h13, 32'h124, 5'b10001, 32'h1C, 8'h00);

    msr(32'h0000_0053, 4'b0001);
    fiq_req = 1; irq_req = 8'h80; pc_cur = 32'h140; instr_boundary = 1;
    expect_entry("fiq_masked", 32'hD2, 32'h53, 32'h144, 5'b10010, 32'h18, 8'h80);

    msr(32'h0000_0092, 4'b0001);
    fiq_req = 1; irq_req = 8'h01; pc_cur = 32'h160; instr_boundary = 1;
    expect_entry("nest", 32'hD1, 32'h92, 32'h164, 5'b10001, 32'h1C, 8'h00);

    fiq_req = 1; irq_req = 8'hFF; instr_boundary = 1;
    @(negedge clk);
    check_eq("masked.busy", 32'(busy), 32'd0);
    clear_reqs();
    swi_req = 1;
    @(negedge clk);
    check_eq("noboundary.busy", 32'(busy), 32'd0);
    clear_reqs();

    msr(32'h0000_0010, 4'b0001);
    und_req = 1; swi_req = 1; pc_cur = 32'h300; instr_boundary = 1;
    expect_entry("und", 32'h9B, 32'h10, 32'h300, 5'b11011, 32'h04, 8'h00);

    msr(32'h0000_0010, 4'b0001);
    swi_req = 1; pc_cur = 32'h200; instr_boundary = 1;
    expect_entry("swi", 32'h93, 32'h10, 32'h200, 5'b10011, 32'h08, 8'h00);

    eret_req = 1; eret_pc = 32'h200; instr_boundary = 1;
    @(negedge clk);
    clear_reqs();
    check_eq("eret.busy", 32'(busy), 32'd1);
    check_eq("eret.pc_we", 32'(pc_we), 32'd1);
    check_eq("eret.pc_new", pc_new, 32'h200);
    check_eq("eret.rf_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    check_eq("eret.cpsr", cpsr, 32'h10);
    check_eq("eret.idle", 32'(busy), 32'd0);

    msr(32'hF000_00D3, 4'b1111);
    check_eq("usr.msr", cpsr, 32'hF000_0010);
    nzcv_wr_en = 1; nzcv = 4'h4;
    msr(32'h2000_0000, 4'b1000);
    nzcv_wr_en = 0;
    check_eq("nzcv.vs_msr", cpsr, 32'h2000_0010);
    nzcv_wr_en = 1; nzcv = 4'h8;
    @(negedge clk);
    nzcv_wr_en = 0;
    check_eq("nzcv.only", cpsr, 32'h8000_0010);

    eret_req = 1; eret_pc = 32'h444; instr_boundary = 1;
    @(negedge clk);
    clear_reqs();
    check_eq("eret_usr.pc_new", pc_new, 32'h444);
    @(negedge clk);
    check_eq("eret_usr.cpsr", cpsr, 32'h8000_0010);

    swi_req = 1; pc_cur = 32'h500; instr_boundary = 1;
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    check_eq("abort.link", 32'(rf_we), 32'd1);
    rst = 1;
    #1;
    check_eq("abort.cpsr", cpsr, 32'h0000_00D3);
    check_eq("abort.busy", 32'(busy), 32'd0);
    check_eq("abort.rf_we", 32'(rf_we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort.pc_we_rst", 32'(pc_we), 32'd0);
    end
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort.pc_we_post", 32'(pc_we), 32'd0);
      check_eq("abort.busy_post", 32'(busy), 32'd0);
    end
    check_eq("abort.cpsr_post", cpsr, 32'h0000_00D3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
